// File: rtl/shift_add_multiply_if.sv
// shift_add_multiply_if
// Request/result bundle for the shift-add multiplier.
//   start         request; acted on only at a rising clk edge where ready=1
//   a, b          operands, captured on the accepting edge
//   sign          1 = two's-complement operands and product, 0 = unsigned
//   ready         1 = idle, product valid, a new request can be accepted
//   prod_hi/lo    upper / lower half of the 2*WIDTH-bit product
//
// Handshake: a transfer happens at the rising clk edge where start=1 and
// ready=1. start while ready=0 is dropped, not queued. ready stays low until
// the product is written, and prod_hi/prod_lo are stable whenever ready=1.
interface shift_add_multiply_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sign;
  logic             ready;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  modport master (
    output start, a, b, sign,
    input  ready, prod_hi, prod_lo
  );

  modport slave (
    input  start, a, b, sign,
    output ready, prod_hi, prod_lo
  );
endinterface

// File: rtl/shift_add_multiply.sv
// shift_add_multiply
// Iterative radix-2 shift-add multiplier, unsigned or two's-complement.
// The operands are turned into magnitudes on entry. The multiply runs one
// multiplier bit per cycle, and the sign is applied in a final fix-up cycle.
// Latency is WIDTH+1 clocks from the accepting edge to ready=1.
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   bus        request/result bundle (slave side)
//   dbg_state  current FSM state (0 = IDLE, 1 = RUN, 2 = FIX)
module shift_add_multiply #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  shift_add_multiply_if.slave  bus,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;

  logic [CW-1:0]    count;
  logic             neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_lo;

  logic [WIDTH-1:0]   in_mag_a;
  logic [WIDTH-1:0]   in_mag_b;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] fixed;

  // Datapath arithmetic.
  always_comb begin
    // Magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1).
    in_mag_a = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    in_mag_b = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // The carry out of the add becomes the top bit of hi after the shift.
    sum      = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : {(WIDTH + 1){1'b0}});
    fixed    = neg ? -{hi, lo} : {hi, lo};
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // The last step is the one that takes count from 1 to 0.
        if (count == CW'(1)) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      neg     <= 1'b0;
      mag_a   <= '0;
      hi      <= '0;
      lo      <= '0;
      prod_hi <= '0;
      prod_lo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg   <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            mag_a <= in_mag_a;
            hi    <= '0;
            lo    <= in_mag_b;
            count <= CW'(WIDTH);
          end
        end
        RUN: begin
          // {hi, lo} <= {sum, lo} >> 1
          hi    <= sum[WIDTH:1];
          lo    <= {sum[0], lo[WIDTH-1:1]};
          count <= count - 1'b1;
        end
        FIX: begin
          prod_hi <= fixed[2*WIDTH-1:WIDTH];
          prod_lo <= fixed[WIDTH-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.ready   = (state == IDLE);
  assign bus.prod_hi = prod_hi;
  assign bus.prod_lo = prod_lo;
  assign dbg_state   = state;

endmodule

// File: tb/tb_shift_add_multiply.sv
// tb_shift_add_multiply
// Directed and random stimulus for shift_add_multiply. A timeline model
// predicts ready and the product each cycle from the arithmetic product.
module tb_shift_add_multiply;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;

  shift_add_multiply_if #(.WIDTH(W)) bus ();

  shift_add_multiply #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [2*W-1:0] act,
                       input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a,
                                              input logic [W-1:0] b,
                                              input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    logic        [2*W-1:0] ua;
    logic        [2*W-1:0] ub;
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      return sa * sb;
    end else begin
      ua = {{W{1'b0}}, a};
      ub = {{W{1'b0}}, b};
      return ua * ub;
    end
  endfunction

  // Scoreboard: an accepted request is busy for W+1 edges, then its product
  // becomes visible.
  logic [2*W-1:0] exp_q[$];
  int             m_busy = 0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0;
      m_prod = '0;
      exp_q.delete();
    end else if (m_busy == 0) begin
      if (bus.start === 1'b1) begin
        exp_q.push_back(ref_prod(bus.a, bus.b, bus.sign));
        m_busy = W + 1;
      end
    end else begin
      m_busy--;
      if (m_busy == 0) m_prod = exp_q.pop_front();
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("ready", {{(2*W-1){1'b0}}, bus.ready}, {{(2*W-1){1'b0}}, (m_busy == 0)});
    check("prod", {bus.prod_hi, bus.prod_lo}, m_prod);
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s);
    @(posedge clk); #2;
    bus.a     = a;
    bus.b     = b;
    bus.sign  = s;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
  endtask

  task automatic wait_ready(output int cyc);
    cyc = 0;
    while (bus.ready !== 1'b1 && cyc < 200) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (bus.ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_ready: ready still %b after %0d cycles", bus.ready, cyc);
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic s,
                        input logic [2*W-1:0] exp);
    int cyc;
    issue(a, b, s);
    wait_ready(cyc);
    check(name, {bus.prod_hi, bus.prod_lo}, exp);
    check({name, "_latency"}, 2*W'(cyc), 2*W'(W + 1));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.sign  = 1'b0;

    // Pin the model against hand-computed products.
    check("model_umax", ref_prod(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0), 64'hFFFFFFFE_00000001);
    check("model_neg1", ref_prod(32'hFFFFFFFF, 32'h1, 1'b1), 64'hFFFFFFFF_FFFFFFFF);
    check("model_min",  ref_prod(32'h80000000, 32'h80000000, 1'b1), 64'h40000000_00000000);

    // Reset state.
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", {63'd0, bus.ready}, 64'd1);
    check("reset_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("idle_ready", {63'd0, bus.ready}, 64'd1);
    check("idle_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);

    // Directed corners.
    run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001);
    run_op("neg_one", 32'hFFFFFFFF, 32'h00000001, 1'b1, 64'hFFFFFFFF_FFFFFFFF);
    run_op("min_sq", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000);
    run_op("mixed", 32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB);

    // A start while busy must be dropped.
    issue(32'd7, 32'd6, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    bus.start = 1'b1;
    @(posedge clk); #2;
    bus.start = 1'b0;
    wait_ready(cyc);
    check("busy_ignored", {bus.prod_hi, bus.prod_lo}, 64'd42);

    // Zero operands, including a negative times zero.
    run_op("zero_signed", 32'hFFFFFFFB, 32'd0, 1'b1, 64'd0);
    run_op("zero_unsigned", 32'd0, 32'hDEADBEEF, 1'b0, 64'd0);
    run_op("prev_nonzero", 32'd100, 32'd100, 1'b0, 64'd10000);

    // Reset in the middle of a run.
    issue(32'd1234, 32'd5678, 1'b0);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrun_ready", {63'd0, bus.ready}, 64'd1);
    check("midrun_prod", {bus.prod_hi, bus.prod_lo}, 64'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    run_op("after_reset", 32'd3, 32'd4, 1'b0, 64'd12);

    // Random, back-to-back with start held high.
    @(posedge clk); #2;
    for (int i = 0; i < 200; i++) begin
      bus.a     = $urandom;
      bus.b     = $urandom;
      bus.sign  = 1'($urandom_range(0, 1));
      bus.start = 1'b1;
      @(posedge clk); #2;
      wait_ready(cyc);
    end
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shift_add_multiply.md
# shift_add_multiply

Iterative radix-2 shift-add multiplier that sits beside the sequential divider in the arithmetic unit. It computes a full-width 2×WIDTH product of two WIDTH-bit operands, either unsigned or two's-complement signed. It uses the same start/ready handshake as the divider, so one controller can drive both.

## Interface
- WIDTH, 32, operand width; product is 2×WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- a  input  WIDTH  multiplicand; captured on the accepting edge.
- b  input  WIDTH  multiplier; captured on the accepting edge.
- sign  input  1  1 = operands and product are two's complement; 0 = unsigned. Captured with a and b.
- ready  output  1  1 = idle, product valid, new start accepted.
- prod_hi  output  WIDTH  upper half of the product.
- prod_lo  output  WIDTH  lower half of the product.

## Operation
- Reset state: ready=1, prod_hi=0, prod_lo=0, state IDLE, counter=0.
- State machine has three states: IDLE, RUN and FIX.
- IDLE (ready=1):
  - On a clock edge with start=1, capture sign.
  - Capture mag_a = (sign & a[WIDTH-1]) ? -a : a; capture mag_b the same way.
  - Capture neg = sign & (a[WIDTH-1] ^ b[WIDTH-1]).
  - Load accumulator {hi=0, lo=mag_b}, set counter=WIDTH, go to RUN.
  - ready falls on this same edge.
- RUN, one step per cycle:
  - sum = {1'b0, hi} + (lo[0] ? mag_a : 0), computed WIDTH+1 bits wide.
  - Then {hi, lo} = {sum, lo} >> 1.
  - Decrement counter; when it reaches 0, go to FIX.
- FIX, one cycle:
  - If neg, prod = -{hi, lo} (2×WIDTH two's-complement negate); otherwise prod = {hi, lo}.
  - Go to IDLE; ready rises on this edge.
- The magnitudes are WIDTH-bit unsigned, so -2^(WIDTH-1) is handled: its magnitude 2^(WIDTH-1) fits.
- prod_hi and prod_lo change only on the FIX edge and otherwise hold their last value, including throughout RUN.
- start while ready=0 is ignored; no queuing.
- start held high continuously: a new operation is accepted on the first edge at which ready=1.
- An operand of zero gives a product of 0 in both modes. neg may be 1 in this case, but -0 = 0.
- Reset asserted mid-operation: immediately returns to IDLE with ready=1 and products 0. The partial result is discarded.

## Timing
- Start is accepted at edge E0.
- ready=0 from E0 until edge E0+WIDTH+1, inclusive of the RUN and FIX cycles.
- Result is valid and ready=1 after edge E0+WIDTH+1, i.e. a latency of WIDTH+1 clocks (33 for the default).
- Minimum issue interval: WIDTH+2 edges (one IDLE edge is needed to accept the next start).
- Outputs are fully registered. There is no combinational path from any input to any output.
- Reset acts asynchronously on assertion; release is synchronous to clk.

## Test plan
- Reset: assert reset -> ready=1, prod_hi=0, prod_lo=0. Release, hold start=0 for 10 cycles -> outputs unchanged.
- Unsigned maximum: a=32'hFFFFFFFF, b=32'hFFFFFFFF, sign=0 -> prod_hi=32'hFFFFFFFE, prod_lo=32'h00000001; ready low for exactly 33 cycles.
- Signed negatives:
  - a=32'hFFFFFFFF (-1), b=1, sign=1 -> prod_hi=32'hFFFFFFFF, prod_lo=32'hFFFFFFFF.
  - a=32'h80000000, b=32'h80000000, sign=1 -> prod_hi=32'h40000000, prod_lo=0.
- Busy and zero handling: start a=7, b=6. Re-pulse start with a=3, b=3 mid-run -> result 42 (prod_lo=32'h2A); the second request is ignored. Then a=-5, b=0, sign=1 -> 0.
- Reset mid-run: start a=1234, b=5678, assert reset at cycle 10 -> ready=1 and outputs 0 immediately. A new start with a=3, b=4 -> prod_lo=12 after 33 cycles.
- Random self-check: 200 random a, b and sign values with back-to-back starts; compare against the reference $signed/$unsigned 64-bit product.
